// File: rtl/icb2wb_uart_bridge.sv
// ICB (32-bit) to 8-bit Wishbone bridge for the UART register block.
// One outstanding transfer, ack timeout aborts a stalled UART access.
module icb2wb_uart_bridge #(
   parameter int AW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_icb_cmd_valid,
   output logic          i_icb_cmd_ready,
   input  logic [AW-1:0] i_icb_cmd_addr,
   input  logic          i_icb_cmd_read,
   input  logic [31:0]   i_icb_cmd_wdata,
   input  logic [3:0]    i_icb_cmd_wmask,
   output logic          i_icb_rsp_valid,
   input  logic          i_icb_rsp_ready,
   output logic [31:0]   i_icb_rsp_rdata,
   output logic          i_icb_rsp_err,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [2:0]    o_wb_addr,
   output logic [7:0]    o_wb_data,
   input  logic          i_wb_ack,
   input  logic [7:0]    i_wb_data
);

   typedef enum logic [1:0] {IDLE, BUS, RSP} state_e;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_e     state_q, state_d;
   logic       cyc_q, cyc_d;
   logic       we_q, we_d;
   logic [2:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic [7:0] rbyte_q, rbyte_d;
   logic       err_q, err_d;
   logic [7:0] cnt_q, cnt_d;

   logic unused_bits;
   assign unused_bits = ^{i_icb_cmd_addr[AW-1:5], i_icb_cmd_wdata[31:8],
                          i_icb_cmd_wmask[3:1]};

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      we_d    = we_q;
      addr_d  = addr_q;
      data_d  = data_q;
      rbyte_d = rbyte_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (i_icb_cmd_valid) begin
               addr_d  = i_icb_cmd_addr[4:2];
               we_d    = ~i_icb_cmd_read;
               data_d  = i_icb_cmd_wdata[7:0];
               rbyte_d = 8'h00;
               cnt_d   = 8'h00;
               if (i_icb_cmd_addr[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = RSP;
               end else if (!i_icb_cmd_read && !i_icb_cmd_wmask[0]) begin
                  err_d   = 1'b0;
                  state_d = RSP;
               end else begin
                  err_d   = 1'b0;
                  cyc_d   = 1'b1;
                  state_d = BUS;
               end
            end
         end
         BUS: begin
            // ack wins over a timeout in the same cycle
            if (i_wb_ack) begin
               cyc_d   = 1'b0;
               err_d   = 1'b0;
               rbyte_d = we_q ? 8'h00 : i_wb_data;
               state_d = RSP;
            end else if (cnt_q == CNT_LAST) begin
               cyc_d   = 1'b0;
               err_d   = 1'b1;
               rbyte_d = 8'h00;
               state_d = RSP;
            end else begin
               cnt_d = cnt_q + 8'h01;
            end
         end
         RSP: begin
            if (i_icb_rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 3'd0;
         data_q  <= 8'h00;
         rbyte_q <= 8'h00;
         err_q   <= 1'b0;
         cnt_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rbyte_q <= rbyte_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign i_icb_cmd_ready = (state_q == IDLE);
   assign i_icb_rsp_valid = (state_q == RSP);
   assign i_icb_rsp_rdata = {24'h0, rbyte_q};
   assign i_icb_rsp_err   = err_q;
   assign o_wb_cyc        = cyc_q;
   assign o_wb_stb        = cyc_q;
   assign o_wb_we         = we_q;
   assign o_wb_addr       = addr_q;
   assign o_wb_data       = data_q;

endmodule

// File: tb/tb_icb2wb_uart_bridge.sv
// Bench for icb2wb_uart_bridge: directed vector table, reset sequence,
// and random transactions against a transaction-level reference model.
module tb_icb2wb_uart_bridge;

   localparam int TO = 16;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_read;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wmask;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        wb_cyc, wb_stb, wb_we, wb_ack;
   logic [2:0]  wb_addr;
   logic [7:0]  wb_wdata, wb_rdata;

   int checks = 0;
   int errors = 0;

   icb2wb_uart_bridge #(.AW(32), .TIMEOUT(TO)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_icb_cmd_valid (cmd_valid),
      .i_icb_cmd_ready (cmd_ready),
      .i_icb_cmd_addr  (cmd_addr),
      .i_icb_cmd_read  (cmd_read),
      .i_icb_cmd_wdata (cmd_wdata),
      .i_icb_cmd_wmask (cmd_wmask),
      .i_icb_rsp_valid (rsp_valid),
      .i_icb_rsp_ready (rsp_ready),
      .i_icb_rsp_rdata (rsp_rdata),
      .i_icb_rsp_err   (rsp_err),
      .o_wb_cyc        (wb_cyc),
      .o_wb_stb        (wb_stb),
      .o_wb_we         (wb_we),
      .o_wb_addr       (wb_addr),
      .o_wb_data       (wb_wdata),
      .i_wb_ack        (wb_ack),
      .i_wb_data       (wb_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      int          ackdly;
      int          rspdly;
      logic [7:0]  ub;
      bit          stray;
      logic        err;
      logic [31:0] rdata;
      int          ncyc;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic vec_t mkv(logic [31:0] a, logic r, logic [31:0] wd,
                                logic [3:0] wm, int ad, int rdl,
                                logic [7:0] ub, bit st, logic e,
                                logic [31:0] rdat, int nc, int lt);
      vec_t v;
      v.addr = a; v.rd = r; v.wdata = wd; v.wmask = wm;
      v.ackdly = ad; v.rspdly = rdl; v.ub = ub; v.stray = st;
      v.err = e; v.rdata = rdat; v.ncyc = nc; v.lat = lt;
      return v;
   endfunction

   // Reference model: outcome of one command from the bridge rules
   function automatic vec_t model(vec_t v);
      bit mis, acc, tmo;
      mis = (v.addr[1:0] != 2'b00);
      acc = !mis && (v.rd || v.wmask[0]);
      tmo = acc && (v.ackdly >= TO);
      v.err   = mis || tmo;
      v.rdata = (acc && !tmo && v.rd) ? {24'h0, v.ub} : 32'h0;
      v.ncyc  = !acc ? 0 : (tmo ? TO : v.ackdly + 1);
      v.lat   = v.ncyc + 1;
      return v;
   endfunction

   task automatic run_txn(input vec_t v);
      int  lat, ccount;
      bit  got, bad, cyc_at_rsp;
      @(negedge clk);
      chk("cmd_ready_idle", {31'h0, cmd_ready}, 1);
      cmd_valid = 1'b1;
      cmd_addr  = v.addr;
      cmd_read  = v.rd;
      cmd_wdata = v.wdata;
      cmd_wmask = v.wmask;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_wdata = $urandom;
      cmd_addr  = $urandom;
      got = 0; bad = 0; lat = 0; ccount = 0; cyc_at_rsp = 0;
      for (int c = 1; c <= 400 && !got; c++) begin
         @(negedge clk);
         if (rsp_valid) begin
            got = 1;
            lat = c;
            cyc_at_rsp = wb_cyc;
            wb_ack = 1'b0;
         end else if (wb_cyc) begin
            ccount++;
            if (wb_stb !== 1'b1 || wb_we !== ~v.rd ||
                wb_addr !== v.addr[4:2] || wb_wdata !== v.wdata[7:0])
               bad = 1;
            wb_ack   = (ccount - 1 == v.ackdly);
            wb_rdata = wb_ack ? v.ub : 8'($urandom);
         end else begin
            wb_ack = 1'b0;
         end
      end
      chk("rsp_valid_seen", {31'h0, got}, 1);
      chk("wb_cycles", ccount, v.ncyc);
      chk("latency", lat, v.lat);
      chk("wb_fields", {31'h0, bad}, 0);
      chk("cyc_low_at_rsp", {31'h0, cyc_at_rsp}, 0);
      chk("rsp_err", {31'h0, rsp_err}, {31'h0, v.err});
      chk("rsp_rdata", rsp_rdata, v.rdata);
      bad = 0;
      for (int h = 0; h < v.rspdly; h++) begin
         cmd_valid = 1'b1;
         cmd_read  = 1'($urandom);
         cmd_addr  = {$urandom} & 32'h1C;
         cmd_wmask = 4'hF;
         wb_ack    = v.stray;
         @(negedge clk);
         if (!rsp_valid || rsp_rdata !== v.rdata || rsp_err !== v.err ||
             cmd_ready !== 1'b0 || wb_cyc !== 1'b0)
            bad = 1;
      end
      if (v.rspdly > 0) chk("rsp_hold", {31'h0, bad}, 0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      wb_ack    = 1'b0;
      @(negedge clk);
      chk("post_rsp", {29'h0, rsp_valid, cmd_ready, wb_cyc}, 32'b010);
   endtask

   vec_t dir[10];
   vec_t rv;

   initial begin
      // addr, rd, wdata, wmask, ackdly, rspdly, ub, stray,
      // err, rdata, ncyc, lat
      dir[0] = mkv(32'h0C, 0, 32'h83, 4'hF, 0, 0, 8'h00, 0, 0, 0, 1, 2);
      dir[1] = mkv(32'h14, 1, 32'h0, 4'hF, 3, 0, 8'h60, 0, 0, 32'h60, 4, 5);
      dir[2] = mkv(32'h08, 0, 32'h55, 4'hE, 0, 0, 8'h00, 0, 0, 0, 0, 1);
      dir[3] = mkv(32'h02, 1, 32'h0, 4'hF, 0, 0, 8'h77, 0, 1, 0, 0, 1);
      dir[4] = mkv(32'h08, 1, 32'h0, 4'hF, 255, 3, 8'h99, 1, 1, 0, 16, 17);
      dir[5] = mkv(32'h04, 1, 32'h0, 4'hF, 0, 0, 8'hA5, 0, 0, 32'hA5, 1, 2);
      dir[6] = mkv(32'h1C, 1, 32'h0, 4'hF, 1, 10, 8'h3C, 0, 0, 32'h3C, 2, 3);
      dir[7] = mkv(32'h10, 1, 32'h0, 4'hF, 15, 0, 8'hC3, 0, 0, 32'hC3, 16, 17);
      dir[8] = mkv(32'hFFFF_FFF0, 0, 32'hAABBCC11, 4'h1, 2, 1, 8'h00, 0,
                   0, 0, 3, 4);
      dir[9] = mkv(32'h13, 0, 32'h12, 4'hF, 0, 0, 8'h00, 0, 1, 0, 0, 1);

      rst_n = 1'b0;
      cmd_valid = 0; cmd_addr = 0; cmd_read = 0; cmd_wdata = 0;
      cmd_wmask = 0; rsp_ready = 0; wb_ack = 0; wb_rdata = 0;
      #12;
      chk("reset_cmd_ready", {31'h0, cmd_ready}, 1);
      chk("reset_ctrl", {27'h0, rsp_valid, rsp_err, wb_cyc, wb_stb, wb_we},
          0);
      chk("reset_rdata", rsp_rdata, 0);
      chk("reset_wb", {21'h0, wb_addr, wb_wdata}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (dir[i]) run_txn(dir[i]);

      // reset in the middle of a Wishbone access
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = 32'h10; cmd_read = 1'b1;
      cmd_wmask = 4'hF;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rst_pre_cyc", {31'h0, wb_cyc}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async", {28'h0, wb_cyc, wb_stb, rsp_valid, cmd_ready},
          32'b0001);
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(mkv(32'h00, 1, 32'h0, 4'hF, 1, 0, 8'h5A, 0,
                  0, 32'h5A, 2, 3));

      for (int n = 0; n < 40; n++) begin
         rv.addr   = {$urandom} & 32'hFFFF_FFFC;
         if ($urandom_range(7) == 0) rv.addr[1:0] = 2'($urandom_range(1, 3));
         rv.rd     = 1'($urandom);
         rv.wdata  = $urandom;
         rv.wmask  = 4'($urandom);
         rv.ackdly = ($urandom_range(5) == 0) ? 255 : $urandom_range(0, 20);
         rv.rspdly = $urandom_range(0, 3);
         rv.ub     = 8'($urandom);
         rv.stray  = 1'($urandom);
         run_txn(model(rv));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/icb2wb_uart_bridge.md
# icb2wb_uart_bridge

Bridges the core's 32-bit ICB peripheral port to the 8-bit Wishbone slave port of the UART wrapper. It sits directly upstream of the UART. Each ICB command becomes at most one single Wishbone transfer. The bridge adds ack-timeout protection so a stalled UART cannot hang the core, and allows one outstanding transaction.

## Interface
- AW, 32: ICB address width.
- TIMEOUT, 16: number of cycles in BUS without ack before the transfer is aborted; legal range 2..255.

Ports (name, direction, width, meaning):
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_icb_cmd_valid  in  1  command valid.
- i_icb_cmd_ready  out  1  command ready.
- i_icb_cmd_addr  in  AW  byte address; bits [4:2] select the UART register, [1:0] must be 0.
- i_icb_cmd_read  in  1  1 = read, 0 = write.
- i_icb_cmd_wdata  in  32  write data; only [7:0] is used.
- i_icb_cmd_wmask  in  4  byte mask; only [0] is used.
- i_icb_rsp_valid  out  1  response valid.
- i_icb_rsp_ready  in  1  response ready.
- i_icb_rsp_rdata  out  32  read data, {24'b0, byte}.
- i_icb_rsp_err  out  1  error response.
- o_wb_cyc  out  1  Wishbone cycle.
- o_wb_stb  out  1  Wishbone strobe.
- o_wb_we  out  1  Wishbone write enable.
- o_wb_addr  out  3  UART register index.
- o_wb_data  out  8  Wishbone write data.
- i_wb_ack  in  1  Wishbone ack from the UART.
- i_wb_data  in  8  Wishbone read data from the UART.

## Operation
- FSM states: IDLE, BUS, RSP. All Wishbone outputs and all response outputs are registered.
- Reset state is IDLE. Output values under reset:
  - cmd_ready = 1.
  - rsp_valid, rsp_err, cyc, stb, we = 0.
  - rsp_rdata, wb_addr, wb_data = 0.
  - Timeout counter = 0.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, capture addr[4:2], read, wdata[7:0], wmask[0], then choose the next state:
  - addr[1:0] != 0 → RSP with err = 1, rdata = 0. No Wishbone access.
  - Write with wmask[0] = 0 → RSP with err = 0, rdata = 0. No Wishbone access.
  - Otherwise → BUS, driving cyc = stb = 1, we = ~read, addr, data. The timeout counter clears to 0.
- BUS:
  - cmd_ready = 0.
  - cyc, stb, we, addr and data are held stable until termination.
  - The counter increments every cycle that ack is low.
  - On i_wb_ack = 1:
    - rdata = read ? {24'b0, i_wb_data} : 0; err = 0.
    - cyc and stb drop on the next edge; go to RSP.
  - If ack is still low when the counter equals TIMEOUT-1:
    - Abort: cyc and stb drop, err = 1, rdata = 0; go to RSP.
  - Ack takes priority over timeout when both occur in the same cycle.
- RSP:
  - cmd_ready = 0; rsp_valid = 1, with rdata and err held stable.
  - On rsp_ready, go to IDLE. rsp_valid drops and cmd_ready rises on the next edge.
- i_wb_ack outside BUS is ignored.
- Reset asserted mid-transaction returns immediately to reset values; the pending response is discarded.
- Address bits [AW-1:5] are ignored. Decode is done upstream.

## Timing
- Cycle 0: cmd handshake.
- Cycle 1: cyc/stb high.
- Ack in cycle k (k ≥ 1): cyc/stb low and rsp_valid high at k+1.
- Minimum command-to-response latency: 2 cycles with a Wishbone access, 1 cycle without.
- Timeout abort: cyc/stb stay high for exactly TIMEOUT cycles; rsp_valid rises at cycle TIMEOUT+1.
- Response handshake cycle r: the next command may be accepted at r+1. Peak throughput is one transfer per 3 cycles.
- cyc/stb never overlap two transactions; there is always at least one cycle low between transfers.

## Test plan
- Write addr 0x0C, wdata 0x0000_0083, wmask 0xF, ack in cycle 1 → one Wishbone write: we = 1, addr = 3, data = 0x83, cyc/stb high for exactly 1 cycle. rsp_valid at cycle 2 with err = 0, rdata = 0.
- Read addr 0x14, UART returns 0x60 with ack after 3 wait cycles → addr = 5, we = 0. rsp_rdata = 0x0000_0060, err = 0, rsp_valid 1 cycle after ack.
- Write with wmask = 4'b1110, then read addr 0x02 → no cyc/stb for either command. Responses: err = 0 for the write, err = 1 with rdata = 0 for the misaligned read.
- Ack held low, TIMEOUT = 16 → cyc/stb high for exactly 16 cycles, then rsp err = 1, rdata = 0. A stray ack 2 cycles later is ignored and the next command completes normally.
- rsp_ready held low 10 cycles after a read → rsp_valid, rdata, err stay stable; cmd_ready stays 0; a new cmd_valid is not accepted until 1 cycle after the response handshake.
- rst_n asserted during BUS → cyc, stb, rsp_valid drop asynchronously and cmd_ready = 1. After release, a read of addr 0x00 completes normally.
